// File: rtl/nrdiv_sched_if.sv
// Requester, divider and response signals of the NR_Div scheduler.
// Latency: none (wiring only).
// Backpressure: none; the scheduler master paces requesters via gnt/req_pop.
interface nrdiv_sched_if #(
    parameter int Block = 128
);
    logic [1:0]       req_valid;
    logic [1:0]       gnt;
    logic [Block-1:0] req0_dividend;
    logic [Block-1:0] req1_dividend;
    logic [Block-1:0] req0_divisor;
    logic [Block-1:0] req1_divisor;
    logic [1:0]       req_pop;
    logic             div_valid_in;
    logic             div_data_vld_in;
    logic [Block-1:0] div_dividend;
    logic [Block-1:0] div_divisor;
    logic [Block-1:0] div_quotient;
    logic             div_data_vld_out;
    logic [Block-1:0] rsp_quot;
    logic             rsp_vld;
    logic             rsp_id;
    logic             rsp_last;
    logic             timeout;
    logic             spurious;

    // Scheduler side.
    modport master (
        input  req_valid, req0_dividend, req1_dividend, req0_divisor, req1_divisor,
        input  div_quotient, div_data_vld_out,
        output gnt, req_pop, div_valid_in, div_data_vld_in, div_dividend, div_divisor,
        output rsp_quot, rsp_vld, rsp_id, rsp_last, timeout, spurious
    );

    // Requester / divider side.
    modport slave (
        output req_valid, req0_dividend, req1_dividend, req0_divisor, req1_divisor,
        output div_quotient, div_data_vld_out,
        input  gnt, req_pop, div_valid_in, div_data_vld_in, div_dividend, div_divisor,
        input  rsp_quot, rsp_vld, rsp_id, rsp_last, timeout, spurious
    );
endinterface

// File: rtl/nrdiv_sched.sv
// Round-robin two-requester scheduler/sequencer for the shared NR_Div divider.
// Latency: grant+start 1 cycle after request, operands streamed next 32 cycles, rsp 1 cycle after quotient.
// Backpressure: none toward the divider; requesters hold req_valid until gnt and advance on req_pop.
module nrdiv_sched #(
    parameter int Block   = 128,
    parameter int N_BLK   = 32,
    parameter int M_BLK   = 16,
    parameter int TIMEOUT = 4096
) (
    input logic          clk,
    input logic          rst_n,
    nrdiv_sched_if.master bus
);
    localparam int BW  = $clog2(N_BLK);
    localparam int QW  = $clog2(M_BLK);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, FEED, WAIT} state_t;

    state_t           state;
    logic             id;        // requester currently being served
    logic             last_srv;  // requester served last; reset makes requester 0 win a tie
    logic [BW-1:0]    blk;       // dividend block index being presented to the divider
    logic [QW-1:0]    qcnt;      // quotient blocks received so far
    logic [WDW-1:0]   wd;        // cycles since START, START included
    logic [Block-1:0] sel_dvd;
    logic [Block-1:0] sel_dvs;
    logic             nxt_id;
    logic             collect;
    logic             q_last;
    logic             wd_exp;

    assign sel_dvd = id ? bus.req1_dividend : bus.req0_dividend;
    assign sel_dvs = id ? bus.req1_divisor  : bus.req0_divisor;
    assign nxt_id  = (&bus.req_valid) ? ~last_srv : bus.req_valid[1];
    assign collect = (state == FEED) || (state == WAIT);
    assign q_last  = collect && bus.div_data_vld_out && (qcnt == QW'(M_BLK - 1));
    assign wd_exp  = (wd == WDW'(TIMEOUT));

    // One pop per block taken: START captures block 0, FEED k captures block k+1.
    assign bus.req_pop = ((state == START) || ((state == FEED) && (blk != BW'(N_BLK - 1))))
                         ? bus.gnt : 2'b00;

    // Arbitration, operand sequencing, quotient collection and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            id                  <= 1'b0;
            last_srv            <= 1'b1;
            blk                 <= '0;
            qcnt                <= '0;
            wd                  <= '0;
            bus.gnt             <= 2'b00;
            bus.div_valid_in    <= 1'b0;
            bus.div_data_vld_in <= 1'b0;
            bus.div_dividend    <= '0;
            bus.div_divisor     <= '0;
            bus.rsp_quot        <= '0;
            bus.rsp_vld         <= 1'b0;
            bus.rsp_id          <= 1'b0;
            bus.rsp_last        <= 1'b0;
            bus.timeout         <= 1'b0;
            bus.spurious        <= 1'b0;
        end else begin
            bus.div_valid_in <= 1'b0;
            bus.rsp_vld      <= 1'b0;
            bus.rsp_last     <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.spurious     <= 1'b0;

            case (state)
                IDLE: begin
                    // Late quotients after an abort land here.
                    if (bus.div_data_vld_out) begin
                        bus.spurious <= 1'b1;
                    end
                    if (|bus.req_valid) begin
                        id               <= nxt_id;
                        bus.gnt          <= {nxt_id, ~nxt_id};
                        bus.div_valid_in <= 1'b1;
                        wd               <= WDW'(1);
                        qcnt             <= '0;
                        state            <= START;
                    end
                end
                START: begin
                    bus.div_data_vld_in <= 1'b1;
                    bus.div_dividend    <= sel_dvd;
                    bus.div_divisor     <= sel_dvs;
                    blk                 <= '0;
                    wd                  <= wd + WDW'(1);
                    state               <= FEED;
                end
                FEED: begin
                    wd <= wd + WDW'(1);
                    if (blk == BW'(N_BLK - 1)) begin
                        bus.div_data_vld_in <= 1'b0;
                        bus.div_dividend    <= '0;
                        bus.div_divisor     <= '0;
                        state               <= WAIT;
                    end else begin
                        bus.div_dividend <= sel_dvd;
                        // Only the first M_BLK blocks carry divisor; the rest are zero-padded.
                        bus.div_divisor  <= (blk < BW'(M_BLK - 1)) ? sel_dvs : '0;
                        blk              <= blk + BW'(1);
                    end
                end
                WAIT: begin
                    wd <= wd + WDW'(1);
                end
                default: state <= IDLE;
            endcase

            // Quotients are accepted as soon as feeding starts.
            if (collect && bus.div_data_vld_out) begin
                bus.rsp_quot <= bus.div_quotient;
                bus.rsp_vld  <= 1'b1;
                bus.rsp_id   <= id;
                qcnt         <= qcnt + QW'(1);
            end

            // Completion wins over a watchdog expiry in the same cycle.
            if (q_last) begin
                bus.rsp_last        <= 1'b1;
                bus.gnt             <= 2'b00;
                last_srv            <= id;
                bus.div_data_vld_in <= 1'b0;
                bus.div_dividend    <= '0;
                bus.div_divisor     <= '0;
                state               <= IDLE;
            end else if ((state != IDLE) && wd_exp) begin
                bus.timeout         <= 1'b1;
                bus.gnt             <= 2'b00;
                bus.div_valid_in    <= 1'b0;
                bus.div_data_vld_in <= 1'b0;
                bus.div_dividend    <= '0;
                bus.div_divisor     <= '0;
                state               <= IDLE;
            end
        end
    end
endmodule
